// File: rtl/prefetch_pkg.sv
// prefetch_pkg
//   Shared definitions for the instruction prefetcher:
//     - state_t        : RUN / DRAIN state encoding
//     - INSTR_BYTES    : size of one instruction word in bytes
//     - PC_ALIGN_BITS  : number of low pc bits that are always zero
//     - PC_ALIGN_MASK  : mask of those low bits (cleared on redirect)
package prefetch_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam int INSTR_BYTES   = 4;
    localparam int PC_ALIGN_BITS = 2;
    localparam logic [PC_ALIGN_BITS-1:0] PC_ALIGN_MASK = '1;

endpackage

// File: rtl/credit_counter.sv
// credit_counter
//   Tracks reads that still hold FIFO credit (in_flight) and stale reads
//   that must be discarded after a redirect (drop_cnt).
//   A read holds its credit from grant until its word is written to the
//   FIFO, or until it returns as a stale response.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   issue         request granted this cycle
//   write         FIFO write strobe active this cycle
//   stale         a response is discarded this cycle
//   redirect      redirect strobe; reloads drop_cnt
//   space         free FIFO entries
//   credit_ok     a new read may be issued
//   drop_nxt_nz   drop_cnt will be non-zero next cycle
module credit_counter #(
    parameter int MAX_OUT = 2,
    parameter int SPACE_W = 3,
    parameter int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue,
    input  logic               write,
    input  logic               stale,
    input  logic               redirect,
    input  logic [SPACE_W-1:0] space,
    output logic               credit_ok,
    output logic               drop_nxt_nz
);

    logic [CW-1:0] in_flight;
    logic [CW-1:0] in_flight_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_nxt;

    always_comb begin
        in_flight_nxt = in_flight + CW'(issue) - CW'(write) - CW'(stale);
        drop_nxt      = drop_cnt;
        // Everything still outstanding after a redirect cycle is stale.
        if (redirect) begin
            drop_nxt = in_flight_nxt;
        end else if (stale) begin
            drop_nxt = drop_cnt - CW'(1);
        end
    end

    assign drop_nxt_nz = (drop_nxt != '0);
    assign credit_ok   = (32'(in_flight) < 32'(MAX_OUT)) &&
                         (32'(in_flight) < 32'(space));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
            drop_cnt  <= '0;
        end else begin
            in_flight <= in_flight_nxt;
            drop_cnt  <= drop_nxt;
        end
    end

    a_in_flight_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        (32'(in_flight) + 32'(issue)) >= (32'(write) + 32'(stale)));

    a_drop_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        (stale && !redirect) |-> (drop_cnt != '0));

endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch
//   Issues sequential instruction reads and pushes returned words into the
//   downstream instruction FIFO. Outstanding reads are limited by the FIFO
//   free space; a redirect flushes the FIFO and discards stale responses.
//   Optional macro PREFETCH_PC_TAG_EN: a becomes {pc_of_word, instruction}
//   and a small tag queue remembers the pc of each outstanding read.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   en                      fetch enable (gates new issues only)
//   redirect, redirect_pc   one-cycle redirect and its target
//   space                   free FIFO entries
//   mem_req, mem_addr       read request / address (pc register)
//   mem_gnt                 request accepted
//   mem_rvalid, mem_rdata   in-order read response
//   a, we                   registered FIFO write data / strobe
//   flush                   registered one-cycle FIFO clear
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | issuing reads, writing returned words to the FIFO
// ST_DRAIN | waiting for stale responses after a redirect, no issue
module instr_prefetch
    import prefetch_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           MAX_OUT  = 2,
    parameter int           SPACE_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               redirect,
    input  logic [N-1:0]       redirect_pc,
    input  logic [SPACE_W-1:0] space,
    output logic               mem_req,
    output logic [N-1:0]       mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [N-1:0]       mem_rdata,
`ifdef PREFETCH_PC_TAG_EN
    output logic [2*N-1:0]     a,
`else
    output logic [N-1:0]       a,
`endif
    output logic               we,
    output logic               flush
);

    localparam int CW = $clog2(MAX_OUT + 1);

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] pc;
    logic         credit_ok;
    logic         drop_nxt_nz;
    logic         issue;
    logic         stale;
    logic         accept;

    // rst_n keeps the request quiet while the block is held in reset.
    always_comb begin
        mem_req   = 1'b0;
        state_nxt = state;
        if (rst_n && (state == ST_RUN) && en && !redirect && credit_ok) begin
            mem_req = 1'b1;
        end
        if (redirect || (state == ST_DRAIN)) begin
            state_nxt = drop_nxt_nz ? ST_DRAIN : ST_RUN;
        end
    end

    assign issue    = mem_req & mem_gnt;
    // A response arriving in the redirect cycle already belongs to the old path.
    assign stale    = mem_rvalid & (redirect | (state == ST_DRAIN));
    assign accept   = mem_rvalid & ~stale;
    assign mem_addr = pc;

    credit_counter #(
        .MAX_OUT (MAX_OUT),
        .SPACE_W (SPACE_W),
        .CW      (CW)
    ) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (issue),
        .write       (we),
        .stale       (stale),
        .redirect    (redirect),
        .space       (space),
        .credit_ok   (credit_ok),
        .drop_nxt_nz (drop_nxt_nz)
    );

`ifdef PREFETCH_PC_TAG_EN
    localparam int IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [N-1:0]  tag_q [MAX_OUT];
    logic [IW-1:0] tag_wp;
    logic [IW-1:0] tag_rp;
    logic [N-1:0]  word_pc;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(MAX_OUT - 1)) ? '0 : p + IW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_q[tag_wp] <= pc;
        end
    end

    // Stale responses pop too, so the queue stays aligned with the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wp <= '0;
            tag_rp <= '0;
        end else begin
            if (issue) begin
                tag_wp <= ptr_inc(tag_wp);
            end
            if (mem_rvalid) begin
                tag_rp <= ptr_inc(tag_rp);
            end
        end
    end

    assign word_pc = tag_q[tag_rp];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
            we    <= 1'b0;
            flush <= 1'b0;
            a     <= '0;
        end else begin
            state <= state_nxt;
            flush <= redirect;
            we    <= accept;
            if (redirect) begin
                pc <= redirect_pc & ~N'(PC_ALIGN_MASK);
            end else if (issue) begin
                pc <= pc + N'(INSTR_BYTES);
            end
            if (accept) begin
`ifdef PREFETCH_PC_TAG_EN
                a <= {word_pc, mem_rdata};
`else
                a <= mem_rdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
module tb_instr_prefetch;

`ifdef PREFETCH_PC_TAG_EN
    localparam int AW = 64;
`else
    localparam int AW = 32;
`endif
    localparam int MAX_OUT = 2;
    localparam int FIFO_DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic [2:0]    space = 3'd4;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic [AW-1:0] a;
    logic          we;
    logic          flush;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    instr_prefetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .space       (space),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .a           (a),
        .we          (we),
        .flush       (flush)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] mk_a(input logic [31:0] t, input logic [31:0] d);
        logic [63:0] full;
        full = {t, d};
        return full[AW-1:0];
    endfunction

    typedef struct {
        logic        en;
        logic [2:0]  space;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_tag;
        logic [31:0] e_data;
        logic        e_flush;
    } vec_t;

    vec_t vt [22];

    // Reference model: one ticket per granted read, removed when written or
    // when it comes back stale.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
        bit          returned;
        int          icyc;
    } tk_t;

    tk_t         tq[$];
    logic [31:0] pc_m;
    int          fcnt;
    logic        we_prev;
    logic        flush_prev;

    initial begin
        int  idx;
        bit  draining;
        bit  req_exp;
        bit  rv;
        bit  exp_we;
        logic [AW-1:0] exp_a;
        tk_t nt;

        //            en    space  gnt   rv    rdata          redir rpc            req   addr           we    tag            data           flush
        vt[0]  = '{1'b1, 3'd4, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0};
        vt[1]  = '{1'b1, 3'd4, 1'b1, 1'b1, 32'h11110000,  1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         32'h11110000,  1'b0};
        vt[2]  = '{1'b1, 3'd4, 1'b1, 1'b1, 32'h22220004,  1'b0, 32'h0,         1'b0, 32'h8,         1'b1, 32'h4,         32'h22220004,  1'b0};
        vt[3]  = '{1'b1, 3'd4, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8,         1'b0, 32'h0,         32'h0,         1'b0};
        vt[4]  = '{1'b1, 3'd4, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0,         32'h0,         1'b0};
        vt[5]  = '{1'b1, 3'd4, 1'b1, 1'b0, 32'h0,         1'b1, 32'h103,       1'b0, 32'h10,        1'b0, 32'h0,         32'h0,         1'b1};
        vt[6]  = '{1'b1, 3'd4, 1'b1, 1'b1, 32'hDEAD0008,  1'b0, 32'h0,         1'b0, 32'h100,       1'b0, 32'h0,         32'h0,         1'b0};
        vt[7]  = '{1'b1, 3'd4, 1'b1, 1'b1, 32'hDEAD000C,  1'b0, 32'h0,         1'b0, 32'h100,       1'b0, 32'h0,         32'h0,         1'b0};
        vt[8]  = '{1'b1, 3'd4, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0,         32'h0,         1'b0};
        vt[9]  = '{1'b1, 3'd4, 1'b0, 1'b1, 32'h44440100,  1'b0, 32'h0,         1'b1, 32'h104,       1'b1, 32'h100,       32'h44440100,  1'b0};
        vt[10] = '{1'b1, 3'd4, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFFFFFE,  1'b0, 32'h104,       1'b0, 32'h0,         32'h0,         1'b1};
        vt[11] = '{1'b1, 3'd4, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hFFFFFFFC,  1'b0, 32'h0,         32'h0,         1'b0};
        vt[12] = '{1'b1, 3'd4, 1'b1, 1'b1, 32'h5555FFFC,  1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFFFFFC,  32'h5555FFFC,  1'b0};
        vt[13] = '{1'b1, 3'd4, 1'b1, 1'b1, 32'h66660000,  1'b1, 32'h200,       1'b0, 32'h4,         1'b0, 32'h0,         32'h0,         1'b1};
        vt[14] = '{1'b1, 3'd4, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h0,         32'h0,         1'b0};
        vt[15] = '{1'b0, 3'd4, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h200,       1'b0, 32'h0,         32'h0,         1'b0};
        vt[16] = '{1'b1, 3'd1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h0,         32'h0,         1'b0};
        vt[17] = '{1'b1, 3'd1, 1'b1, 1'b1, 32'h77770200,  1'b0, 32'h0,         1'b0, 32'h204,       1'b1, 32'h200,       32'h77770200,  1'b0};
        vt[18] = '{1'b1, 3'd1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h204,       1'b0, 32'h0,         32'h0,         1'b0};
        vt[19] = '{1'b1, 3'd1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h204,       1'b0, 32'h0,         32'h0,         1'b0};
        vt[20] = '{1'b1, 3'd4, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h204,       1'b0, 32'h0,         32'h0,         1'b0};
        vt[21] = '{1'b1, 3'd4, 1'b0, 1'b1, 32'h88880204,  1'b0, 32'h0,         1'b1, 32'h208,       1'b1, 32'h204,       32'h88880204,  1'b0};

        // Reset values
        #2;
        chk("rst_req",   64'(mem_req),  64'(0));
        chk("rst_addr",  64'(mem_addr), 64'(0));
        chk("rst_we",    64'(we),       64'(0));
        chk("rst_flush", 64'(flush),    64'(0));
        chk("rst_a",     64'(a),        64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            en          = vt[i].en;
            space       = vt[i].space;
            mem_gnt     = vt[i].gnt;
            mem_rvalid  = vt[i].rv;
            mem_rdata   = vt[i].rdata;
            redirect    = vt[i].redir;
            redirect_pc = vt[i].rpc;
            #1;
            chk($sformatf("tbl%0d_req", i),  64'(mem_req),  64'(vt[i].e_req));
            chk($sformatf("tbl%0d_addr", i), 64'(mem_addr), 64'(vt[i].e_addr));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_we", i),    64'(we),    64'(vt[i].e_we));
            chk($sformatf("tbl%0d_flush", i), 64'(flush), 64'(vt[i].e_flush));
            if (vt[i].e_we) begin
                chk($sformatf("tbl%0d_a", i), 64'(a), 64'(mk_a(vt[i].e_tag, vt[i].e_data)));
            end
        end

        // Reset mid-operation: a word is being written and a read is pending.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we",    64'(we),       64'(0));
        chk("midrst_a",     64'(a),        64'(0));
        chk("midrst_addr",  64'(mem_addr), 64'(0));
        chk("midrst_req",   64'(mem_req),  64'(0));
        chk("midrst_flush", 64'(flush),    64'(0));
        @(negedge clk);
        en = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; redirect = 1'b0; space = 3'd4;
        rst_n = 1'b1;
        tq.delete();
        pc_m = 32'h0;
        fcnt = 0;
        we_prev = 1'b0;
        flush_prev = 1'b0;

        // Randomized traffic against the ticket model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (flush_prev) begin
                fcnt = 0;
            end else if (we_prev) begin
                fcnt++;
                chk("fifo_no_overflow", 64'(fcnt <= FIFO_DEPTH), 64'(1));
            end
            if (fcnt > 0 && ($urandom % 2) == 0) fcnt--;
            if (flush) chk("flush_we_apart", 64'(we), 64'(0));
            we_prev = we;
            flush_prev = flush;

            en          = ($urandom % 8) != 0;
            redirect    = ($urandom % 25) == 0;
            redirect_pc = $urandom;
            mem_gnt     = ($urandom % 4) != 0;
            space       = 3'(FIFO_DEPTH - fcnt);
            idx = (tq.size() > 0 && tq[0].returned) ? 1 : 0;
            rv  = (idx < tq.size()) && (tq[idx].icyc < c) && (($urandom % 3) != 0);
            mem_rvalid = rv;
            mem_rdata  = $urandom;

            draining = 1'b0;
            for (int k = 0; k < tq.size(); k++) if (tq[k].stale) draining = 1'b1;
            req_exp = en && !redirect && !draining &&
                      (tq.size() < MAX_OUT) && (tq.size() < (FIFO_DEPTH - fcnt));
            #1;
            chk("rnd_req",  64'(mem_req),  64'(req_exp));
            chk("rnd_addr", 64'(mem_addr), 64'(pc_m));

            exp_we = 1'b0;
            exp_a  = '0;
            if (tq.size() > 0 && tq[0].returned) void'(tq.pop_front());
            if (rv) begin
                if (tq[0].stale || redirect) begin
                    void'(tq.pop_front());
                end else begin
                    tq[0].returned = 1'b1;
                    exp_we = 1'b1;
                    exp_a  = mk_a(tq[0].addr, mem_rdata);
                end
            end
            if (req_exp && mem_gnt) begin
                nt.addr = pc_m; nt.stale = 1'b0; nt.returned = 1'b0; nt.icyc = c;
                tq.push_back(nt);
            end
            if (redirect) begin
                for (int k = 0; k < tq.size(); k++) if (!tq[k].returned) tq[k].stale = 1'b1;
                pc_m = redirect_pc & ~32'h3;
            end else if (req_exp && mem_gnt) begin
                pc_m = pc_m + 32'h4;
            end

            @(posedge clk);
            #1;
            chk("rnd_we",    64'(we),    64'(exp_we));
            chk("rnd_flush", 64'(flush), 64'(redirect));
            if (exp_we) chk("rnd_a", 64'(a), 64'(exp_a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
